// File: rtl/clock_set_controller.sv
// Time-set sequencer: turns debounced mode/adjust buttons into field select, inc pulses and blink.
// Optional auto-repeat on a held adjust button is enabled with `define CLOCK_SET_AUTOREPEAT_EN.
module clock_set_controller #(
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned TIMEOUT_S       = 30,
    parameter int unsigned BLINK_HZ        = 2,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       tick_1Hz,
    input  logic       btn_mode,
    input  logic       btn_adj,
    output logic [1:0] set_mode,
    output logic       run_en,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       inc_sec,
    output logic       blink_on
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        SET_SEC  = 2'b11
    } mode_e;

    localparam int unsigned BLINK_TC_RAW = CLK_HZ / (2 * BLINK_HZ);
    localparam int unsigned BLINK_TC     = (BLINK_TC_RAW > 1) ? BLINK_TC_RAW : 1;
    localparam int unsigned BLINK_W      = (BLINK_TC > 1) ? $clog2(BLINK_TC) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TC - 1);
    localparam logic [7:0]         IDLE_LAST  = 8'(TIMEOUT_S - 1);

    if (TIMEOUT_S < 1 || TIMEOUT_S > 255) begin : g_bad_timeout
        $error("TIMEOUT_S must be in 1..255");
    end
    if (BLINK_HZ < 1) begin : g_bad_blink
        $error("BLINK_HZ must be at least 1");
    end
    if (REPEAT_RATE_MS < 1 || REPEAT_DELAY_MS * (CLK_HZ / 1000) < 2) begin : g_bad_repeat
        $error("auto-repeat timing too short for this clock");
    end

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int unsigned MS_CYC    = CLK_HZ / 1000;
    localparam int unsigned DELAY_CYC = MS_CYC * REPEAT_DELAY_MS;
    localparam int unsigned RATE_CYC  = MS_CYC * REPEAT_RATE_MS;
    localparam int unsigned REP_MAX   = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
    localparam int unsigned REP_W     = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_LOAD = REP_W'(DELAY_CYC - 1);
    localparam logic [REP_W-1:0] REP_RATE = REP_W'(RATE_CYC);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    logic             rep_active_q, rep_active_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_fire;
`endif

    mode_e              state_q, state_d;
    logic               run_en_q, run_en_d;
    logic               inc_hour_q, inc_hour_d;
    logic               inc_min_q, inc_min_d;
    logic               inc_sec_q, inc_sec_d;
    logic               blink_q, blink_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [7:0]         idle_q, idle_d;
    logic               mode_prev_q, adj_prev_q;

    logic mode_edge, adj_edge, in_set, timeout_hit, adj_pulse, state_chg;

    always_comb begin
        mode_edge   = btn_mode & ~mode_prev_q;
        adj_edge    = btn_adj & ~adj_prev_q;
        in_set      = (state_q != RUN);
        timeout_hit = in_set & tick_1Hz & (idle_q == IDLE_LAST);
`ifdef CLOCK_SET_AUTOREPEAT_EN
        rep_fire    = rep_active_q & btn_adj & (rep_cnt_q == REP_ONE);
`endif

        state_d   = state_q;
        adj_pulse = 1'b0;
        // Priority: timeout, then mode edge, then adjust (edge or repeat).
        if (timeout_hit) begin
            state_d = RUN;
        end else if (mode_edge) begin
            state_d = mode_e'(state_q + 2'd1);
        end else if (in_set && adj_edge) begin
            adj_pulse = 1'b1;
`ifdef CLOCK_SET_AUTOREPEAT_EN
        end else if (in_set && rep_fire) begin
            adj_pulse = 1'b1;
`endif
        end
        state_chg = (state_d != state_q);

        inc_hour_d = adj_pulse & (state_q == SET_HOUR);
        inc_min_d  = adj_pulse & (state_q == SET_MIN);
        inc_sec_d  = adj_pulse & (state_q == SET_SEC);
        run_en_d   = (state_d == RUN);

        if (state_d == RUN || state_chg || mode_edge || adj_edge || adj_pulse) begin
            idle_d = '0;
        end else if (tick_1Hz) begin
            idle_d = idle_q + 8'd1;
        end else begin
            idle_d = idle_q;
        end

        if (state_d == RUN || state_chg || adj_pulse) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
        end else begin
            blink_d     = blink_q;
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

`ifdef CLOCK_SET_AUTOREPEAT_EN
        // Repeat only arms from a genuine press in the current SET state.
        rep_active_d = rep_active_q;
        rep_cnt_d    = rep_cnt_q;
        if (!btn_adj || state_chg || state_d == RUN) begin
            rep_active_d = 1'b0;
            rep_cnt_d    = '0;
        end else if (adj_pulse && adj_edge) begin
            rep_active_d = 1'b1;
            rep_cnt_d    = REP_LOAD;
        end else if (rep_fire) begin
            rep_cnt_d    = REP_RATE;
        end else if (rep_active_q) begin
            rep_cnt_d    = rep_cnt_q - 1'b1;
        end
`endif
    end

    // Previous-level registers reset high so a button held through reset gives no edge.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            run_en_q     <= 1'b1;
            inc_hour_q   <= 1'b0;
            inc_min_q    <= 1'b0;
            inc_sec_q    <= 1'b0;
            blink_q      <= 1'b1;
            blink_cnt_q  <= '0;
            idle_q       <= '0;
            mode_prev_q  <= 1'b1;
            adj_prev_q   <= 1'b1;
`ifdef CLOCK_SET_AUTOREPEAT_EN
            rep_active_q <= 1'b0;
            rep_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            run_en_q     <= run_en_d;
            inc_hour_q   <= inc_hour_d;
            inc_min_q    <= inc_min_d;
            inc_sec_q    <= inc_sec_d;
            blink_q      <= blink_d;
            blink_cnt_q  <= blink_cnt_d;
            idle_q       <= idle_d;
            mode_prev_q  <= btn_mode;
            adj_prev_q   <= btn_adj;
`ifdef CLOCK_SET_AUTOREPEAT_EN
            rep_active_q <= rep_active_d;
            rep_cnt_q    <= rep_cnt_d;
`endif
        end
    end

    assign set_mode = state_q;
    assign run_en   = run_en_q;
    assign inc_hour = inc_hour_q;
    assign inc_min  = inc_min_q;
    assign inc_sec  = inc_sec_q;
    assign blink_on = blink_q;

endmodule
